food_spawn_ctrl: RTL
====================

FOOD_SPAWN_CTRL -- requirements
Module: food_spawn_ctrl

Interface
REQ-001 Parameter GRID_SIZE, default 12, grid edge length in cells.
REQ-002 Parameter CELLS, default 144, cell count (GRID_SIZE*GRID_SIZE).
REQ-003 Parameter LFSR_SEED, default 8'hA5, LFSR reset value; SHALL be nonzero.
REQ-004 iVGA_CLK  in  1  sole clock; all state changes on rising edge.
REQ-005 iRST_n  in  1  reset, synchronous, active-low.
REQ-006 spawn_req  in  1  request a new food cell; sampled only in IDLE.
REQ-007 grid_occupancy  in  144  one bit per cell, index = y*12+x; 1 = occupied.
REQ-008 avoid_x, avoid_y  in  4 each  cell treated as occupied (pending head position).
REQ-009 fixed_start  in  1  1 = use fixed_idx as scan start, not the LFSR.
REQ-010 fixed_idx  in  8  debug scan start index.
REQ-011 spawn_busy  out  1  high in SEED and SCAN.
REQ-012 spawn_done  out  1  one-cycle pulse: free cell found.
REQ-013 spawn_fail  out  1  one-cycle pulse: no free cell.
REQ-014 food_x, food_y  out  4 each  registered food position.
REQ-015 set_valid  out  1  one-cycle pulse, coincident with spawn_done.
REQ-016 set_index  out  8  cell index to mark occupied; valid while set_valid.

Function
REQ-017 FSM states SHALL be IDLE, SEED, SCAN, DONE, FAIL.
REQ-018 IDLE: spawn_req=1 at an edge SHALL move to SEED; otherwise stay.
REQ-019 SEED: scan index = (fixed_start ? fixed_idx : lfsr) mod 144 (subtract 144 if >=144, once for the LFSR; modulo for fixed_idx); check counter = 0; go to SCAN.
REQ-020 SCAN: one cell per cycle; a cell is free iff grid_occupancy[idx]=0 and idx != avoid_y*12+avoid_x.
REQ-021 Free cell SHALL latch food_x=idx%12, food_y=idx/12, set_index=idx, then go to DONE.
REQ-022 Occupied cell: idx increments, 143 wraps to 0; counter increments.
REQ-023 If the 144th check finds no free cell, go to FAIL; food_x/food_y unchanged.
REQ-024 DONE: spawn_done=1 and set_valid=1 for exactly this cycle, then IDLE.
REQ-025 FAIL: spawn_fail=1 for exactly this cycle, then IDLE.
REQ-026 Latency: when the start cell is free, spawn_done SHALL assert in the 3rd cycle after the edge that accepted spawn_req. A hit on the k-th check (k=1..144) asserts it in cycle 2+k. spawn_fail asserts in cycle 146.
REQ-027 spawn_req while not IDLE SHALL be ignored, not queued.
REQ-028 grid_occupancy and avoid_* SHALL be sampled live each SCAN cycle; the caller holds them stable while spawn_busy=1.
REQ-029 The 8-bit Fibonacci LFSR (taps 8,6,5,4) SHALL advance every cycle regardless of state and never reach zero.
REQ-030 avoid_x/avoid_y >= 12 SHALL exclude no cell.

Reset
REQ-031 iRST_n=0 at an edge SHALL force IDLE from any state, including mid-scan.
REQ-032 Reset values: spawn_busy, spawn_done, spawn_fail, set_valid = 0; set_index = 0; food_x = 2, food_y = 2; lfsr = LFSR_SEED.
REQ-033 A spawn_req during reset SHALL be discarded.

Structure
REQ-034 Shared package SHALL hold GRID_SIZE, CELLS, the FSM state encoding, and the LFSR tap constant.
REQ-035 The LFSR SHALL be one sub-module, spawn_lfsr (clock, reset, 8-bit value out).
REQ-036 The index-to-x/y split SHALL use a counter pair tracked alongside idx, not a divider.

Verification
REQ-037 Empty grid, fixed_start=1, fixed_idx=26, request -> spawn_done in cycle 3; food=(2,2); set_index=26.
REQ-038 All cells occupied except 143, fixed_idx=0 -> spawn_done in cycle 146; food=(11,11).
REQ-039 Grid all ones -> spawn_fail in cycle 146; food unchanged; no set_valid.
REQ-040 Empty grid, fixed_idx=143, avoid=(11,11) -> wraps; food=(0,0); done in cycle 4.
REQ-041 Reset asserted at the 10th SCAN cycle -> next cycle spawn_busy=0, food=(2,2), no done pulse.
REQ-042 Second spawn_req while busy -> ignored; exactly one spawn_done results.

Source files
------------

// File: rtl/food_spawn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : food_spawn_ctrl_pkg
// Description : Shared constants, FSM state encoding and helper function
//               for the food spawn controller. The grid is GRID_SIZE cells
//               on each edge, and cell index = y*GRID_SIZE + x.
// Revision    : 1.0 - initial release
// ============================================================================
package food_spawn_ctrl_pkg;

  localparam int GRID_SIZE = 12;
  localparam int CELLS     = 144;

  // Fibonacci feedback taps 8,6,5,4 (1-based), as a mask over bits [7:0].
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEED = 3'd1,
    ST_SCAN = 3'd2,
    ST_DONE = 3'd3,
    ST_FAIL = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } cell_xy_t;

  // Splits a start index (< CELLS) into x/y with a compare chain against
  // row base addresses. This runs once per request, when the scan is
  // seeded; during the scan itself x/y are stepped as counters.
  function automatic cell_xy_t idx_to_xy(input logic [7:0] idx);
    cell_xy_t   r_xy;
    logic [7:0] base;
    r_xy.y = '0;
    base   = '0;
    for (int i = 1; i < GRID_SIZE; i++) begin
      if (idx >= 8'(i * GRID_SIZE)) begin
        r_xy.y = 4'(i);
        base   = 8'(i * GRID_SIZE);
      end
    end
    r_xy.x = 4'(idx - base);
    return r_xy;
  endfunction

endpackage
`default_nettype wire

// File: rtl/food_spawn_ctrl_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : spawn_lfsr
// Description : 8-bit Fibonacci LFSR (taps 8,6,5,4), free-running. It
//               advances on every clock edge, and its polynomial is maximal
//               length, so a nonzero seed never reaches the all-zero state.
// Ports       : i_clk    - clock
//               i_rst_n  - synchronous active-low reset (loads SEED)
//               o_value  - current LFSR value
// Revision    : 1.0 - initial release
// ============================================================================
module spawn_lfsr
  import food_spawn_ctrl_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [7:0] o_value
);

  logic [7:0] r_lfsr;
  logic       w_fb;

  assign w_fb = ^(r_lfsr & LFSR_TAPS);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
    end
  end

  assign o_value = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/food_spawn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : food_spawn_ctrl
// Description : Finds a free grid cell for a new food item. On a request it
//               seeds a scan index (from the LFSR or a fixed debug index),
//               then checks one cell per cycle and wraps around the grid
//               until it finds a free cell or has checked every cell.
// Ports       : iVGA_CLK       - clock
//               iRST_n         - synchronous active-low reset
//               spawn_req      - start request, sampled only while idle
//               grid_occupancy - 1 bit per cell, 1 = occupied
//               avoid_x/_y     - extra cell treated as occupied
//               fixed_start    - use fixed_idx as scan start instead of LFSR
//               fixed_idx      - debug scan start index
//               spawn_busy     - high while seeding or scanning
//               spawn_done     - 1-cycle pulse, free cell found
//               spawn_fail     - 1-cycle pulse, no free cell
//               food_x/_y      - registered food position
//               set_valid      - 1-cycle pulse with spawn_done
//               set_index      - cell index to mark occupied
// Revision    : 1.0 - initial release
// ============================================================================
module food_spawn_ctrl
  import food_spawn_ctrl_pkg::*;
#(
  parameter int         GRID_SIZE = 12,
  parameter int         CELLS     = 144,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic             iVGA_CLK,
  input  logic             iRST_n,
  input  logic             spawn_req,
  input  logic [CELLS-1:0] grid_occupancy,
  input  logic [3:0]       avoid_x,
  input  logic [3:0]       avoid_y,
  input  logic             fixed_start,
  input  logic [7:0]       fixed_idx,
  output logic             spawn_busy,
  output logic             spawn_done,
  output logic             spawn_fail,
  output logic [3:0]       food_x,
  output logic [3:0]       food_y,
  output logic             set_valid,
  output logic [7:0]       set_index
);

  state_t     r_state;
  state_t     w_state_nxt;

  logic [7:0] w_lfsr;
  logic [7:0] w_start_raw;
  logic [7:0] w_start;
  cell_xy_t   w_start_xy;

  logic [7:0] r_idx;
  logic [7:0] r_cnt;
  logic [3:0] r_cx;
  logic [3:0] r_cy;
  logic [3:0] r_food_x;
  logic [3:0] r_food_y;
  logic [7:0] r_set_index;

  logic       w_free;
  logic       w_last;
  logic       w_wrap;

  spawn_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .i_clk   (iVGA_CLK),
    .i_rst_n (iRST_n),
    .o_value (w_lfsr)
  );

  // Both start sources are below 2*CELLS, so one conditional subtract
  // reduces them modulo CELLS.
  assign w_start_raw = fixed_start ? fixed_idx : w_lfsr;
  assign w_start     = (w_start_raw >= 8'(CELLS)) ? (w_start_raw - 8'(CELLS))
                                                  : w_start_raw;
  assign w_start_xy  = idx_to_xy(w_start);

  // The avoid cell is compared on x/y directly, so a coordinate >= GRID_SIZE
  // can never match a real cell and therefore excludes nothing.
  assign w_free = !grid_occupancy[r_idx] &&
                  !((r_cx == avoid_x) && (r_cy == avoid_y));
  assign w_last = (r_cnt == 8'(CELLS - 1));
  assign w_wrap = (r_idx == 8'(CELLS - 1));

  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    spawn_busy  = 1'b0;
    spawn_done  = 1'b0;
    spawn_fail  = 1'b0;
    set_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (spawn_req) begin
          w_state_nxt = ST_SEED;
        end
      end
      ST_SEED: begin
        spawn_busy  = 1'b1;
        w_state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        spawn_busy = 1'b1;
        if (w_free) begin
          w_state_nxt = ST_DONE;
        end else if (w_last) begin
          w_state_nxt = ST_FAIL;
        end
      end
      ST_DONE: begin
        spawn_done  = 1'b1;
        set_valid   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_FAIL: begin
        spawn_fail  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Scan datapath: idx, check counter and the x/y counter pair move together.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_food_x    <= 4'd2;
      r_food_y    <= 4'd2;
      r_set_index <= '0;
    end else begin
      case (r_state)
        ST_SEED: begin
          r_idx <= w_start;
          r_cnt <= '0;
          r_cx  <= w_start_xy.x;
          r_cy  <= w_start_xy.y;
        end
        ST_SCAN: begin
          if (w_free) begin
            r_food_x    <= r_cx;
            r_food_y    <= r_cy;
            r_set_index <= r_idx;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (w_wrap) begin
              r_idx <= '0;
              r_cx  <= '0;
              r_cy  <= '0;
            end else begin
              r_idx <= r_idx + 8'd1;
              if (r_cx == 4'(GRID_SIZE - 1)) begin
                r_cx <= '0;
                r_cy <= r_cy + 4'd1;
              end else begin
                r_cx <= r_cx + 4'd1;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign food_x    = r_food_x;
  assign food_y    = r_food_y;
  assign set_index = r_set_index;

endmodule
`default_nettype wire
